// File: rtl/prob_gen_arbiter_if.sv
// Bus between the learning-rule requesters and the shared stochastic bit generator.
//   req        : per-requester draw request (level, held until ack)
//   prob       : packed N-bit probabilities, requester i at prob[i*N +: N]
//   seed_load  : load seed_value into the LFSR this cycle
//   seed_value : LFSR load value (0 selects the default seed)
//   ack        : one-hot, one-cycle draw-completion pulse
//   bit_out    : per-requester Bernoulli result, held until that requester's next draw
//   busy       : generator is mid-draw (not IDLE)
interface prob_gen_arbiter_if #(
    parameter int unsigned N       = 7,
    parameter int unsigned NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ*N-1:0] prob;
    logic                 seed_load;
    logic [15:0]          seed_value;
    logic [NUM_REQ-1:0]   ack;
    logic [NUM_REQ-1:0]   bit_out;
    logic                 busy;

    modport master (
        output req, prob, seed_load, seed_value,
        input  ack, bit_out, busy
    );

    modport slave (
        input  req, prob, seed_load, seed_value,
        output ack, bit_out, busy
    );
endinterface

// File: rtl/prob_gen_arbiter.sv
// Round-robin time-shared Bernoulli bit generator backed by one 16-bit Galois LFSR.
// Each granted draw runs IDLE -> DRAW -> RESP; the result is 1 when lfsr[N-1:0] < prob.
//   i_clk : clock
//   i_rst : synchronous active-high reset
//   bus   : slave side of prob_gen_arbiter_if (req/prob/seed in, ack/bit_out/busy out)
module prob_gen_arbiter #(
    parameter int unsigned N         = 7,
    parameter int unsigned NUM_REQ   = 4,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    prob_gen_arbiter_if.slave     bus
);
    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned SUM_W = IDX_W + 1;
    localparam logic [15:0] TAPS  = 16'hB400;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DRAW = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             r_state;
    logic [15:0]        r_lfsr;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [IDX_W-1:0]   r_idx;
    logic [N-1:0]       r_p_lat;
    logic [NUM_REQ-1:0] r_ack;
    logic [NUM_REQ-1:0] r_bit_out;
    logic               r_busy;

    logic               w_grant_vld;
    logic [IDX_W-1:0]   w_grant_idx;
    logic [N-1:0]       w_grant_prob;
    logic [SUM_W-1:0]   w_cand;
    logic [IDX_W-1:0]   w_cand_idx;
    logic               w_hit;
    logic [15:0]        w_lfsr_step;
    logic [15:0]        w_seed;

    // Round-robin search: walk downward so the last match is the first set bit at/after rr_ptr.
    always_comb begin
        w_grant_vld  = 1'b0;
        w_grant_idx  = '0;
        w_grant_prob = '0;
        w_cand       = '0;
        w_cand_idx   = '0;
        for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
            w_cand = SUM_W'(r_rr_ptr) + SUM_W'(k);
            if (w_cand >= SUM_W'(NUM_REQ)) begin
                w_cand = w_cand - SUM_W'(NUM_REQ);
            end
            w_cand_idx = IDX_W'(w_cand);
            if (bus.req[w_cand_idx]) begin
                w_grant_vld  = 1'b1;
                w_grant_idx  = w_cand_idx;
                w_grant_prob = bus.prob[w_cand_idx*N +: N];
            end
        end
    end

    // Draw comparison, LFSR next step and zero-safe seed selection.
    always_comb begin
        w_hit       = (r_lfsr[N-1:0] < r_p_lat);
        w_lfsr_step = (r_lfsr >> 1) ^ (r_lfsr[0] ? TAPS : 16'h0000);
        w_seed      = (bus.seed_value == 16'h0000) ? LFSR_SEED : bus.seed_value;
    end

    // FSM, LFSR and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_lfsr    <= LFSR_SEED;
            r_rr_ptr  <= '0;
            r_idx     <= '0;
            r_p_lat   <= '0;
            r_ack     <= '0;
            r_bit_out <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_ack <= '0;

            // A seed load wins over the DRAW advance; the DRAW compare still sees the old value.
            if (bus.seed_load) begin
                r_lfsr <= w_seed;
            end else if (r_state == S_DRAW) begin
                r_lfsr <= w_lfsr_step;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_grant_vld) begin
                        r_idx   <= w_grant_idx;
                        r_p_lat <= w_grant_prob;
                        r_busy  <= 1'b1;
                        r_state <= S_DRAW;
                    end
                end
                S_DRAW: begin
                    // Registering the result here makes ack/bit_out visible during RESP.
                    r_ack[r_idx]     <= 1'b1;
                    r_bit_out[r_idx] <= w_hit;
                    r_state          <= S_RESP;
                end
                S_RESP: begin
                    r_rr_ptr <= (r_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_idx + IDX_W'(1);
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ack     = r_ack;
    assign bus.bit_out = r_bit_out;
    assign bus.busy    = r_busy;
endmodule

// File: tb/tb_prob_gen_arbiter.sv
// Self-checking bench for prob_gen_arbiter: vector table, scoreboard queue and corner sequences.
module tb_prob_gen_arbiter;
    localparam int unsigned N       = 7;
    localparam int unsigned NUM_REQ = 4;
    localparam logic [15:0] SEED    = 16'hACE1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    prob_gen_arbiter_if #(.N(N), .NUM_REQ(NUM_REQ)) bus ();

    prob_gen_arbiter #(.N(N), .NUM_REQ(NUM_REQ), .LFSR_SEED(SEED)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct packed {
        logic [1:0] idx;
        logic       bitv;
    } exp_t;

    typedef struct {
        logic [15:0]  seed;
        int           idx;
        logic [N-1:0] p;
        logic         expv;
    } vec_t;

    exp_t        sb[$];
    vec_t        tbl[8];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] m_lfsr;
    logic        mon_en = 1'b0;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        logic [15:0] s;
        s = v >> 1;
        if (v[0]) s = s ^ 16'hB400;
        return s;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        n_checks++;
        if (act !== req_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req_v, $time);
        end
    endtask

    // Scoreboard: every ack pops the oldest expected draw.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en && bus.ack !== 4'b0000) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", 32'(bus.ack), 32'h0);
            end else begin
                e = sb.pop_front();
                check("ack_onehot", 32'(bus.ack), 32'(4'b0001 << e.idx));
                check("bit_out", 32'(bus.bit_out[e.idx]), 32'(e.bitv));
            end
        end
    end

    task automatic wait_drain();
        for (int k = 0; k < 12 && sb.size() != 0; k++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", 32'(sb.size()), 32'h0);
            sb.delete();
        end
    endtask

    task automatic do_reset(input int cyc);
        @(negedge clk);
        rst            = 1'b1;
        bus.req        = '0;
        bus.seed_load  = 1'b0;
        bus.seed_value = '0;
        repeat (cyc) @(negedge clk);
        rst    = 1'b0;
        m_lfsr = SEED;
    endtask

    task automatic load_seed(input logic [15:0] v);
        @(negedge clk);
        bus.seed_load  = 1'b1;
        bus.seed_value = v;
        @(negedge clk);
        bus.seed_load  = 1'b0;
        m_lfsr = (v == 16'h0000) ? SEED : v;
    endtask

    task automatic draw_exp(input int idx, input logic [N-1:0] p, input logic expv);
        @(negedge clk);
        bus.req[idx]         = 1'b1;
        bus.prob[idx*N +: N] = p;
        sb.push_back('{idx: 2'(idx), bitv: expv});
        m_lfsr = lfsr_next(m_lfsr);
        @(negedge clk);
        bus.req[idx] = 1'b0;
        wait_drain();
    endtask

    task automatic draw_model(input int idx, input logic [N-1:0] p);
        draw_exp(idx, p, (m_lfsr[N-1:0] < p));
    endtask

    initial begin
        logic [N-1:0] pr[4];
        int           n_acks;
        int           ones;
        int           bad_gap;
        int           last_c;
        int           c;

        // r values: 0x0001->1, ACE1->0x61, 0x0080->0, 0xFFFF->0x7F, 0x007E->0x7E
        tbl[0] = '{seed: 16'h0001, idx: 0, p: 7'd1,   expv: 1'b0};
        tbl[1] = '{seed: 16'h0001, idx: 0, p: 7'd2,   expv: 1'b1};
        tbl[2] = '{seed: 16'h0000, idx: 3, p: 7'h61,  expv: 1'b0};
        tbl[3] = '{seed: 16'h0000, idx: 3, p: 7'h62,  expv: 1'b1};
        tbl[4] = '{seed: 16'h0080, idx: 1, p: 7'd0,   expv: 1'b0};
        tbl[5] = '{seed: 16'h0080, idx: 1, p: 7'd1,   expv: 1'b1};
        tbl[6] = '{seed: 16'hFFFF, idx: 2, p: 7'd127, expv: 1'b0};
        tbl[7] = '{seed: 16'h007E, idx: 2, p: 7'd127, expv: 1'b1};

        rst            = 1'b1;
        bus.req        = '0;
        bus.prob       = '0;
        bus.seed_load  = 1'b0;
        bus.seed_value = '0;

        // Reset values and first draw from the reset seed
        do_reset(2);
        mon_en = 1'b1;
        @(negedge clk);
        check("rst_ack", 32'(bus.ack), 32'h0);
        check("rst_bit_out", 32'(bus.bit_out), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        draw_exp(0, 7'd127, 1'b1);

        // Vector table
        for (int i = 0; i < 8; i++) begin
            load_seed(tbl[i].seed);
            draw_exp(tbl[i].idx, tbl[i].p, tbl[i].expv);
        end

        // prob = 0 never yields 1
        for (int i = 0; i < 64; i++) draw_exp(0, 7'd0, 1'b0);

        // Round-robin order and timing with all requests held
        do_reset(2);
        pr[0] = 7'd127; pr[1] = 7'd0; pr[2] = 7'd64; pr[3] = 7'd32;
        @(negedge clk);
        for (int i = 0; i < 4; i++) bus.prob[i*N +: N] = pr[i];
        bus.req = 4'hF;
        for (int i = 0; i < 5; i++) begin
            sb.push_back('{idx: 2'(i % 4), bitv: (m_lfsr[N-1:0] < pr[i % 4])});
            m_lfsr = lfsr_next(m_lfsr);
        end
        for (int cc = 0; cc < 15; cc++) begin
            check("rr_busy", 32'(bus.busy), 32'((cc % 3) != 0));
            check("rr_ack_time", 32'(bus.ack != 4'b0000), 32'((cc % 3) == 2));
            if (cc == 14) bus.req = '0;
            @(negedge clk);
        end
        wait_drain();

        // Seed load during DRAW: current draw uses old lfsr, next draw uses the loaded value
        @(negedge clk);
        bus.req[0]       = 1'b1;
        bus.prob[0 +: N] = 7'd127;
        sb.push_back('{idx: 2'd0, bitv: (m_lfsr[N-1:0] < 7'd127)});
        @(negedge clk);
        bus.req[0]     = 1'b0;
        bus.seed_load  = 1'b1;
        bus.seed_value = 16'h0001;
        m_lfsr         = 16'h0001;
        @(negedge clk);
        bus.seed_load  = 1'b0;
        wait_drain();
        draw_exp(0, 7'd1, 1'b0);
        draw_model(0, 7'd2);

        // Reset during the DRAW of a req2 draw
        do_reset(2);
        @(negedge clk);
        bus.req[2]       = 1'b1;
        bus.prob[2*N +: N] = 7'd127;
        @(negedge clk);
        rst     = 1'b1;
        bus.req = '0;
        @(negedge clk);
        rst    = 1'b0;
        m_lfsr = SEED;
        for (int i = 0; i < 3; i++) begin
            check("rstmid_ack", 32'(bus.ack), 32'h0);
            check("rstmid_bit2", 32'(bus.bit_out[2]), 32'h0);
            check("rstmid_busy", 32'(bus.busy), 32'h0);
            @(negedge clk);
        end
        bus.prob[1*N +: N] = 7'd127;
        bus.prob[3*N +: N] = 7'd127;
        bus.req = 4'b1010;
        sb.push_back('{idx: 2'd1, bitv: (m_lfsr[N-1:0] < 7'd127)});
        m_lfsr = lfsr_next(m_lfsr);
        @(negedge clk);
        bus.req = '0;
        wait_drain();
        check("rstmid_bit2_after", 32'(bus.bit_out[2]), 32'h0);

        // Statistics: 4096 back-to-back draws on req1 at p = 32/128
        do_reset(2);
        @(negedge clk);
        bus.prob[1*N +: N] = 7'd32;
        bus.req[1] = 1'b1;
        for (int i = 0; i < 4096; i++) begin
            sb.push_back('{idx: 2'd1, bitv: (m_lfsr[N-1:0] < 7'd32)});
            m_lfsr = lfsr_next(m_lfsr);
        end
        n_acks = 0; ones = 0; bad_gap = 0; last_c = -1; c = 0;
        while (n_acks < 4096 && c < 4096 * 3 + 30) begin
            if (bus.ack[1]) begin
                n_acks++;
                if (bus.bit_out[1]) ones++;
                if (last_c >= 0 && (c - last_c) != 3) bad_gap++;
                last_c = c;
            end
            if (n_acks == 4096) begin
                bus.req = '0;
            end else begin
                @(negedge clk);
                c++;
            end
        end
        check("stat_acks", 32'(n_acks), 32'd4096);
        check("stat_ack_spacing", 32'(bad_gap), 32'h0);
        check("stat_ones_in_range", 32'(ones >= 928 && ones <= 1120), 32'h1);
        $display("stat ones=%0d of %0d draws", ones, n_acks);
        wait_drain();

        repeat (4) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/prob_gen_arbiter.md
# prob_gen_arbiter

Time-shares one stochastic bit generator among `NUM_REQ` requesters, such as synapse or STDP update units. Each requester supplies an `N`-bit probability and receives one Bernoulli bit that is 1 with probability `prob / 2^N`. The block holds the only pseudo-random source (a 16-bit LFSR), arbitrates round-robin and sequences every draw through a 3-state FSM. It sits between the learning-rule units and the random-number resource, so draws never collide and every draw consumes fresh randomness.

## Interface
- `N`, default 7: probability and random-value width. Requirement: N ≤ 15.
- `NUM_REQ`, default 4: number of requesters. Requirement: NUM_REQ ≥ 2.
- `LFSR_SEED`, default 16'hACE1: reset and fallback seed. Must be nonzero.

- `clk`  in  1: the single clock.
- `rst`  in  1: synchronous reset, active-high.
- `req`  in  NUM_REQ: per-requester draw request, level-sensitive.
- `prob`  in  NUM_REQ*N: packed probabilities. Requester i uses `prob[i*N +: N]`.
- `seed_load`  in  1: load the LFSR this cycle.
- `seed_value`  in  16: value loaded by `seed_load`.
- `ack`  out  NUM_REQ: one-hot, one-cycle pulse marking draw completion.
- `bit_out`  out  NUM_REQ: per-requester result. Updated only with that requester's `ack` and held until its next draw.
- `busy`  out  1: high whenever the FSM is not in IDLE.

## Operation
**FSM states**
- IDLE:
  - If any `req` bit is set, grant the first set bit searching upward from `rr_ptr`, wrapping modulo NUM_REQ.
  - Latch `idx` and `prob[idx]` into `p_lat`, then go to DRAW.
  - If no request is set, stay in IDLE.
- DRAW:
  - Compute `r = lfsr[N-1:0]` and `hit = (r < p_lat)`, an unsigned N-bit compare. Register `hit`.
  - Advance the LFSR one step. Go to RESP.
- RESP:
  - Pulse `ack[idx]` and write `bit_out[idx] = hit`.
  - Set `rr_ptr = (idx+1) mod NUM_REQ`. Go to IDLE.

**Probability mapping**
- `p_lat = 0` never yields 1.
- `p_lat = 2^N-1` yields 0 only when `r = 2^N-1`.

**LFSR**
- 16-bit Galois, right-shifting: `lfsr <= (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 0)`.
- It advances only in DRAW, exactly once per draw.

**Seed load**
- `seed_load` is honoured in any state and overrides the DRAW advance in the same cycle.
- A `seed_value` of 0 loads `LFSR_SEED` instead, which prevents LFSR lockup.
- A DRAW coinciding with `seed_load` uses the pre-load `lfsr` value for `r`.

**Requester rules**
- Hold `req` until `ack`.
- Dropping `req` after grant does not abort the draw: `ack` and `bit_out` are still produced.
- A `prob` change after grant has no effect on the current draw.
- A requester that keeps `req` high after `ack` competes again in the next IDLE. Round-robin serves the others first.

**Reset**
- Any cycle with `rst` high forces state IDLE, `lfsr = LFSR_SEED`, `rr_ptr = 0`, `ack = 0`, `bit_out = 0` and `busy = 0`.
- An in-flight draw is discarded: no `ack` is issued.
- `rst` has priority over `seed_load`.

## Timing
- Everything is registered on the rising edge of `clk`. `ack`, `bit_out` and `busy` come straight from flops.
- Latency:
  - `req` seen in IDLE at cycle t means DRAW at t+1.
  - `ack` and the new `bit_out` are valid at t+2.
  - IDLE resumes at t+3.
- Throughput is one draw per 3 cycles. The arbitration decision uses only `req` as sampled in IDLE cycles.
- `busy` is 1 during the DRAW and RESP cycles and 0 in IDLE.
- A requester with `req` held continuously waits at most 3·NUM_REQ cycles for `ack`.

## Test plan
- **Reset values.** Assert `rst` for 2 cycles, then idle with no requests. Required: `ack = 0`, `bit_out = 0`, `busy = 0`. Checking `lfsr = ACE1` via a single draw with `p = 2^N-1`: `r = 0x61`, so `bit_out = 1`.
- **Deterministic compare.** `seed_load` with `seed_value = 0x0001`, then req0 with `prob0 = 1`. Required: `bit_out[0] = 0` at t+2. Reseed to 0x0001 and repeat with `prob0 = 2`. Required: `bit_out[0] = 1`. With `prob0 = 0`, 64 draws must all give 0.
- **Round-robin order.** Hold all 4 `req` bits high for 15 cycles. Required: `ack` sequence 0,1,2,3,0 at cycles 2, 5, 8, 11, 14, and `busy` low at cycles 3, 6, 9, 12.
- **Seed edge cases.** `seed_load` with `seed_value = 0` must load 0xACE1. `seed_load` during DRAW: `r` comes from the old `lfsr` and the next draw uses `seed_value`.
- **Reset mid-operation.** Assert `rst` in the DRAW cycle of a req2 draw. Required: no `ack[2]`, `bit_out[2]` stays 0, and the next grant goes to the lowest requesting index from `rr_ptr = 0`.
- **Statistics.** Run 4096 draws on req1 with `prob1 = 32` (N=7). Required: the count of 1s is within 1024 ± 96, and `ack` arrives exactly every 3 cycles.
